// File: rtl/max_pool_2x2_if.sv
// Stream bundle between the quantizer, the 2x2 max-pool stage and the next layer.
// The master side feeds input samples and accepts pooled results.
interface max_pool_2x2_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 / stride-2 max-pool over a raster-ordered feature map.
// A half-width row buffer holds the top-row horizontal maxima until the bottom row arrives.
module max_pool_2x2 #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAP_WIDTH  = 28,
    parameter int unsigned MAP_HEIGHT = 28
) (
    input logic           clk,
    input logic           rst,
    max_pool_2x2_if.slave bus
);
    localparam int unsigned HALF_W = MAP_WIDTH / 2;
    localparam int unsigned COL_W  = $clog2(MAP_WIDTH + 1);
    localparam int unsigned ROW_W  = $clog2(MAP_HEIGHT + 1);
    localparam int unsigned IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(MAP_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MAP_HEIGHT - 1);

    typedef logic [DATA_WIDTH-1:0] sample_t;

    function automatic sample_t umax(input sample_t a, input sample_t b);
        return (a > b) ? a : b;
    endfunction

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    sample_t          pair_q, pair_d;
    sample_t          row_buf_q [HALF_W];
    sample_t          row_buf_d [HALF_W];
    sample_t          out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;

    logic             in_fire;
    logic             out_fire;
    logic [IDX_W-1:0] buf_idx;
    sample_t          h_max;

    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;

    always_comb begin
        in_fire     = bus.in_valid && bus.in_ready;
        out_fire    = out_valid_q && bus.out_ready;
        buf_idx     = IDX_W'(col_q >> 1);
        h_max       = umax(pair_q, bus.in_data);

        col_d       = col_q;
        row_d       = row_q;
        pair_d      = pair_q;
        row_buf_d   = row_buf_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (out_fire) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        // A result loaded in the same cycle as an output transfer overrides the clear above.
        if (in_fire) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end

            if (!col_q[0]) begin
                pair_d = bus.in_data;
            end else if (!row_q[0]) begin
                row_buf_d[buf_idx] = h_max;
            end else begin
                out_data_d  = umax(row_buf_q[buf_idx], h_max);
                out_valid_d = 1'b1;
                out_last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
            end
        end
    end

    always_ff @(posedge clk) begin
        row_buf_q <= row_buf_d;
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            pair_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            pair_q      <= pair_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end
endmodule

// File: tb/tb_max_pool_2x2.sv
// Bench for max_pool_2x2: a 4x4 instance for directed cases and a 28x28 instance
// for back-to-back random maps, both checked against a spatial 2x2 max-pool model.
module tb_max_pool_2x2;
    logic        clk;
    logic        rst;
    int unsigned cyc;
    int          errors;
    int          checks;

    max_pool_2x2_if #(.DATA_WIDTH(8)) bus_s ();
    max_pool_2x2_if #(.DATA_WIDTH(8)) bus_b ();

    max_pool_2x2 #(.DATA_WIDTH(8), .MAP_WIDTH(4), .MAP_HEIGHT(4)) u_small (
        .clk(clk), .rst(rst), .bus(bus_s)
    );
    max_pool_2x2 #(.DATA_WIDTH(8), .MAP_WIDTH(28), .MAP_HEIGHT(28)) u_big (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    logic [7:0]  s_out_data [$];
    logic        s_out_last [$];
    int unsigned s_out_cyc  [$];
    int unsigned s_in_cyc   [$];
    logic [7:0]  b_out_data [$];
    logic        b_out_last [$];
    logic [7:0]  pix_q      [$];
    logic [7:0]  exp_q      [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Handshake values are stable from the negedge up to the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_s.in_valid && bus_s.in_ready) s_in_cyc.push_back(cyc);
            if (bus_s.out_valid && bus_s.out_ready) begin
                s_out_data.push_back(bus_s.out_data);
                s_out_last.push_back(bus_s.out_last);
                s_out_cyc.push_back(cyc);
            end
            if (bus_b.out_valid && bus_b.out_ready) begin
                b_out_data.push_back(bus_b.out_data);
                b_out_last.push_back(bus_b.out_last);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: each output is the largest of the four pixels in its 2x2 tile.
    function automatic void ref_pool(input int unsigned base, input int unsigned w, input int unsigned h);
        logic [7:0] m;
        for (int unsigned r = 0; r < h; r += 2) begin
            for (int unsigned c = 0; c < w; c += 2) begin
                m = pix_q[base + r * w + c];
                if (pix_q[base + r * w + c + 1] > m)       m = pix_q[base + r * w + c + 1];
                if (pix_q[base + (r + 1) * w + c] > m)     m = pix_q[base + (r + 1) * w + c];
                if (pix_q[base + (r + 1) * w + c + 1] > m) m = pix_q[base + (r + 1) * w + c + 1];
                exp_q.push_back(m);
            end
        end
    endfunction

    task automatic clear_small();
        s_out_data.delete();
        s_out_last.delete();
        s_out_cyc.delete();
        s_in_cyc.delete();
    endtask

    task automatic send_s(input logic [7:0] v);
        int unsigned n;
        n = 0;
        bus_s.in_valid = 1'b1;
        bus_s.in_data  = v;
        while (1) begin
            @(negedge clk);
            if (bus_s.in_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_s timeout: in_ready=%0b required 1", bus_s.in_ready);
                break;
            end
        end
    endtask

    task automatic send_b(input logic [7:0] v);
        int unsigned n;
        n = 0;
        bus_b.in_valid = 1'b1;
        bus_b.in_data  = v;
        while (1) begin
            @(negedge clk);
            if (bus_b.in_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_b timeout: in_ready=%0b required 1", bus_b.in_ready);
                break;
            end
        end
    endtask

    task automatic stream_small();
        for (int i = 0; i < pix_q.size(); i++) send_s(pix_q[i]);
        bus_s.in_valid = 1'b0;
    endtask

    task automatic wait_small(input int unsigned n);
        int unsigned k;
        k = 0;
        while (s_out_data.size() < n && k < 100) begin
            @(posedge clk);
            #2;
            k++;
        end
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_s.in_valid = 1'b0; bus_s.in_data = '0; bus_s.out_ready = 1'b1;
        bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks += 8;
        if (bus_s.out_valid !== 1'b0) begin errors++; $display("FAIL reset_s_out_valid: got %0b expected 0", bus_s.out_valid); end
        if (bus_s.out_data !== 8'd0)  begin errors++; $display("FAIL reset_s_out_data: got %0d expected 0", bus_s.out_data); end
        if (bus_s.out_last !== 1'b0)  begin errors++; $display("FAIL reset_s_out_last: got %0b expected 0", bus_s.out_last); end
        if (bus_s.in_ready !== 1'b1)  begin errors++; $display("FAIL reset_s_in_ready: got %0b expected 1", bus_s.in_ready); end
        if (bus_b.out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_out_valid: got %0b expected 0", bus_b.out_valid); end
        if (bus_b.out_data !== 8'd0)  begin errors++; $display("FAIL reset_b_out_data: got %0d expected 0", bus_b.out_data); end
        if (bus_b.out_last !== 1'b0)  begin errors++; $display("FAIL reset_b_out_last: got %0b expected 0", bus_b.out_last); end
        if (bus_b.in_ready !== 1'b1)  begin errors++; $display("FAIL reset_b_in_ready: got %0b expected 1", bus_b.in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_raster();
        int unsigned beat;
        clear_small();
        pix_q.delete(); exp_q.delete();
        for (int i = 0; i < 16; i++) pix_q.push_back(8'(i));
        ref_pool(0, 4, 4);
        stream_small();
        wait_small(4);
        checks++;
        if (s_out_data.size() != 4) begin errors++; $display("FAIL raster_count: got %0d expected 4", s_out_data.size()); end
        checks++;
        if (s_in_cyc.size() != 16) begin errors++; $display("FAIL raster_in_count: got %0d expected 16", s_in_cyc.size()); end
        for (int i = 0; i < 4 && i < s_out_data.size(); i++) begin
            checks += 2;
            if (s_out_data[i] !== exp_q[i]) begin errors++; $display("FAIL raster_data[%0d]: got %0d expected %0d", i, s_out_data[i], exp_q[i]); end
            if (s_out_last[i] !== (i == 3)) begin errors++; $display("FAIL raster_last[%0d]: got %0b expected %0b", i, s_out_last[i], i == 3); end
            if (s_in_cyc.size() == 16) begin
                beat = (2 * (i / 2) + 1) * 4 + 2 * (i % 2) + 1;
                checks++;
                if (s_out_cyc[i] !== s_in_cyc[beat] + 1)
                    begin errors++; $display("FAIL raster_latency[%0d]: out cycle %0d expected %0d", i, s_out_cyc[i], s_in_cyc[beat] + 1); end
            end
        end
    endtask

    task automatic test_corners();
        clear_small();
        pix_q.delete(); exp_q.delete();
        for (int i = 0; i < 16; i++) pix_q.push_back(8'd10);
        for (int w = 0; w < 4; w++)
            pix_q[(2 * (w / 2) + w / 2) * 4 + 2 * (w % 2) + (w % 2)] = 8'd200;
        ref_pool(0, 4, 4);
        stream_small();
        wait_small(4);
        checks++;
        if (s_out_data.size() != 4) begin errors++; $display("FAIL corners_count: got %0d expected 4", s_out_data.size()); end
        for (int i = 0; i < 4 && i < s_out_data.size(); i++) begin
            checks++;
            if (s_out_data[i] !== exp_q[i]) begin errors++; $display("FAIL corners_data[%0d]: got %0d expected %0d", i, s_out_data[i], exp_q[i]); end
        end
    endtask

    task automatic test_unsigned();
        clear_small();
        pix_q.delete(); exp_q.delete();
        for (int i = 0; i < 16; i++) pix_q.push_back(8'($urandom_range(0, 255)));
        pix_q[0] = 8'd127; pix_q[1] = 8'd128; pix_q[4] = 8'd255; pix_q[5] = 8'd0;
        ref_pool(0, 4, 4);
        stream_small();
        wait_small(4);
        checks++;
        if (s_out_data.size() != 4) begin errors++; $display("FAIL unsigned_count: got %0d expected 4", s_out_data.size()); end
        if (s_out_data.size() > 0) begin
            checks++;
            if (s_out_data[0] !== 8'd255) begin errors++; $display("FAIL unsigned_window0: got %0d expected 255", s_out_data[0]); end
        end
        for (int i = 0; i < 4 && i < s_out_data.size(); i++) begin
            checks++;
            if (s_out_data[i] !== exp_q[i]) begin errors++; $display("FAIL unsigned_data[%0d]: got %0d expected %0d", i, s_out_data[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        clear_small();
        pix_q.delete(); exp_q.delete();
        for (int i = 0; i < 16; i++) pix_q.push_back(8'(3 * i + 1));
        ref_pool(0, 4, 4);
        for (int i = 0; i < 6; i++) send_s(pix_q[i]);
        bus_s.out_ready = 1'b0;
        bus_s.in_data   = pix_q[6];
        repeat (5) begin
            @(negedge clk);
            checks += 3;
            if (bus_s.in_ready !== 1'b0)  begin errors++; $display("FAIL bp_in_ready: got %0b expected 0", bus_s.in_ready); end
            if (bus_s.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %0b expected 1", bus_s.out_valid); end
            if (bus_s.out_data !== exp_q[0]) begin errors++; $display("FAIL bp_out_data: got %0d expected %0d", bus_s.out_data, exp_q[0]); end
        end
        @(posedge clk);
        #1;
        checks++;
        if (s_in_cyc.size() != 6) begin errors++; $display("FAIL bp_consumed: got %0d expected 6", s_in_cyc.size()); end
        bus_s.out_ready = 1'b1;
        for (int i = 6; i < 16; i++) send_s(pix_q[i]);
        bus_s.in_valid = 1'b0;
        wait_small(4);
        checks++;
        if (s_out_data.size() != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", s_out_data.size()); end
        for (int i = 0; i < 4 && i < s_out_data.size(); i++) begin
            checks += 2;
            if (s_out_data[i] !== exp_q[i]) begin errors++; $display("FAIL bp_data[%0d]: got %0d expected %0d", i, s_out_data[i], exp_q[i]); end
            if (s_out_last[i] !== (i == 3)) begin errors++; $display("FAIL bp_last[%0d]: got %0b expected %0b", i, s_out_last[i], i == 3); end
        end
    endtask

    task automatic test_reset_midframe();
        clear_small();
        bus_s.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_s(8'(50 + i));
        bus_s.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks += 3;
        if (bus_s.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %0b expected 0", bus_s.out_valid); end
        if (bus_s.out_data !== 8'd0)  begin errors++; $display("FAIL midrst_out_data: got %0d expected 0", bus_s.out_data); end
        if (bus_s.in_ready !== 1'b1)  begin errors++; $display("FAIL midrst_in_ready: got %0b expected 1", bus_s.in_ready); end
        @(posedge clk);
        #1;
        bus_s.out_ready = 1'b1;
        clear_small();
        for (int i = 0; i < 16; i++) send_s(8'd9);
        bus_s.in_valid = 1'b0;
        wait_small(4);
        checks++;
        if (s_out_data.size() != 4) begin errors++; $display("FAIL midrst_count: got %0d expected 4", s_out_data.size()); end
        for (int i = 0; i < 4 && i < s_out_data.size(); i++) begin
            checks += 2;
            if (s_out_data[i] !== 8'd9)     begin errors++; $display("FAIL midrst_data[%0d]: got %0d expected 9", i, s_out_data[i]); end
            if (s_out_last[i] !== (i == 3)) begin errors++; $display("FAIL midrst_last[%0d]: got %0b expected %0b", i, s_out_last[i], i == 3); end
        end
    endtask

    task automatic test_back_to_back();
        bit          done;
        int unsigned gap;
        int unsigned k;
        b_out_data.delete();
        b_out_last.delete();
        pix_q.delete(); exp_q.delete();
        for (int i = 0; i < 2 * 784; i++) pix_q.push_back(8'($urandom_range(0, 255)));
        ref_pool(0, 28, 28);
        ref_pool(784, 28, 28);
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 2 * 784; i++) begin
                    gap = $urandom_range(0, 2);
                    if (gap != 0) begin
                        bus_b.in_valid = 1'b0;
                        repeat (gap) @(posedge clk);
                        #1;
                    end
                    send_b(pix_q[i]);
                end
                bus_b.in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus_b.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus_b.out_ready = 1'b1;
            end
        join
        k = 0;
        while (b_out_data.size() < 392 && k < 2000) begin
            @(posedge clk);
            #2;
            k++;
        end
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (b_out_data.size() != 392) begin errors++; $display("FAIL b2b_count: got %0d expected 392", b_out_data.size()); end
        for (int i = 0; i < 392 && i < b_out_data.size(); i++) begin
            checks += 2;
            if (b_out_data[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %0d expected %0d", i, b_out_data[i], exp_q[i]); end
            if (b_out_last[i] !== (i == 195 || i == 391))
                begin errors++; $display("FAIL b2b_last[%0d]: got %0b expected %0b", i, b_out_last[i], (i == 195 || i == 391)); end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_raster();
        test_corners();
        test_unsigned();
        test_backpressure();
        test_reset_midframe();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
